mc_sync_fifo: RTL

Parametrised multi-channel synchronous FIFO, the successor to the single-channel 16x8 FIFO.
- NUM_CH independent queues share one write port (channel-addressed) and one read port.
- Reads are served by a round-robin arbiter over non-empty channels.
- Used wherever several producers feed one consumer; the class-based FIFO bench is reused with channel awareness.

---
 rtl/mc_fifo_pkg.sv | 23 ++
 rtl/mc_sync_fifo_channel.sv | 76 +++++++
 rtl/mc_sync_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mc_fifo_pkg.sv
// rtl/mc_fifo_pkg.sv - shared defaults, widths, types and constants for the multi-channel FIFO
package mc_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int NUM_CH_DEF     = 4;

    localparam int CH_W  = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH_DEF + 1);

    typedef logic [FIFO_WIDTH_DEF-1:0] data_t;
    typedef logic [CH_W-1:0]           ch_t;
    typedef logic [CNT_W-1:0]          cnt_t;

    localparam logic ACTIVE   = 1'b1;
    localparam logic INACTIVE = 1'b0;

    // Width of an index over n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mc_sync_fifo_channel.sv
// rtl/mc_sync_fifo_channel.sv - single channel queue: storage, wrapping pointers, count and level flags
module fifo_channel
    import mc_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             almostfull,
    output logic             almostempty
);

    localparam int PTR_W    = clog2_min1(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    // Pointers wrap by explicit compare so non-power-of-two depths work; count moves only when one side fires
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    // Pointer and count state; reset discards everything stored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, intentionally left uninitialised by reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign head        = mem[rd_ptr_q];
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almostfull  = (int'(count_q) >= AF_TH);
    assign almostempty = (int'(count_q) <= AE_TH);

endmodule

// File: rtl/mc_sync_fifo.sv
// rtl/mc_sync_fifo.sv - multi-channel synchronous FIFO with round-robin read arbiter; option MC_FIFO_STICKY_ERR_EN
module mc_sync_fifo
    import mc_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int AF_TH      = FIFO_DEPTH - 1,
    parameter int AE_TH      = 1,
    localparam int CH_BITS   = clog2_min1(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [CH_BITS-1:0]    wr_ch,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
`ifdef MC_FIFO_STICKY_ERR_EN
    input  logic                  err_clr,
`endif
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [CH_BITS-1:0]    rd_ch,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [NUM_CH-1:0]     full,
    output logic [NUM_CH-1:0]     empty,
    output logic [NUM_CH-1:0]     almostfull,
    output logic [NUM_CH-1:0]     almostempty
);

    logic [FIFO_WIDTH-1:0] head [NUM_CH];
    logic [NUM_CH-1:0]     push, pop;
    logic [CH_BITS-1:0]    grant;
    logic                  grant_vld;
    int                    idx;

    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic [CH_BITS-1:0]    rd_ch_q, rd_ch_d;
    logic [CH_BITS-1:0]    last_grant_q, last_grant_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  ovf_evt, udf_evt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_channel #(
            .WIDTH (FIFO_WIDTH),
            .DEPTH (FIFO_DEPTH),
            .AF_TH (AF_TH),
            .AE_TH (AE_TH)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .push        (push[c]),
            .pop         (pop[c]),
            .din         (data_in),
            .head        (head[c]),
            .full        (full[c]),
            .empty       (empty[c]),
            .almostfull  (almostfull[c]),
            .almostempty (almostempty[c])
        );
    end

    // Round-robin search over non-empty channels, starting just after the previous grant
    always_comb begin
        grant     = '0;
        grant_vld = INACTIVE;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(last_grant_q) + 1 + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_vld && !empty[idx]) begin
                grant     = CH_BITS'(idx);
                grant_vld = ACTIVE;
            end
        end
    end

    // Per-channel strobes; a full channel still accepts a write when the same cycle drains it
    always_comb begin
        pop  = '0;
        push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c]  = rd_en && grant_vld && (int'(grant) == c);
            push[c] = wr_en && (int'(wr_ch) == c) && (!full[c] || pop[c]);
        end
    end

    // Next values of the registered read/status outputs
    always_comb begin
        data_out_d   = data_out_q;
        rd_ch_d      = rd_ch_q;
        last_grant_d = last_grant_q;
        rd_valid_d   = INACTIVE;
        udf_evt      = rd_en && !grant_vld;
        ovf_evt      = wr_en && !(|push);
        wr_ack_d     = |push;
        if (rd_en && grant_vld) begin
            data_out_d   = head[grant];
            rd_ch_d      = grant;
            last_grant_d = grant;
            rd_valid_d   = ACTIVE;
        end
`ifdef MC_FIFO_STICKY_ERR_EN
        overflow_d  = ovf_evt || (overflow_q && !err_clr);
        underflow_d = udf_evt || (underflow_q && !err_clr);
`else
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;
`endif
    end

    // Output registers; last grant resets to the top channel so the first grant lands on ch0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            rd_ch_q      <= '0;
            last_grant_q <= CH_BITS'(NUM_CH - 1);
            rd_valid_q   <= INACTIVE;
            wr_ack_q     <= INACTIVE;
            overflow_q   <= INACTIVE;
            underflow_q  <= INACTIVE;
        end else begin
            data_out_q   <= data_out_d;
            rd_ch_q      <= rd_ch_d;
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            wr_ack_q     <= wr_ack_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign data_out  = data_out_q;
    assign rd_ch     = rd_ch_q;
    assign rd_valid  = rd_valid_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
